// File: rtl/snn_noc_pkg.sv
// Shared SNN NoC definitions: packet field positions, type codes, node addresses
// and the sum/threshold FSM state encoding.
package snn_noc_pkg;

    localparam int SRC_MSB     = 34;
    localparam int SRC_LSB     = 31;
    localparam int DST_MSB     = 30;
    localparam int DST_LSB     = 27;
    localparam int TYPE_MSB    = 26;
    localparam int TYPE_LSB    = 24;
    localparam int PAYLOAD_MSB = 11;
    localparam int PAYLOAD_LSB = 0;

    // psum packets reuse the type field area as a copy of the source PE id
    localparam int SRCCP_MSB   = 26;
    localparam int SRCCP_LSB   = 23;
    localparam int PAD_MSB     = 22;
    localparam int PAD_LSB     = 8;
    localparam int PSUM_MSB    = 7;
    localparam int PSUM_LSB    = 0;

    localparam int SPIKE_BIT   = 11;
    localparam int MEM_MSB     = 10;

    localparam logic [2:0] TYPE_FILTER = 3'b000;
    localparam logic [2:0] TYPE_IFMAP  = 3'b001;
    localparam logic [2:0] TYPE_SPIKE  = 3'b010;

    localparam logic [3:0] OUT_MEM_ADDR = 4'b0000;
    localparam logic [3:0] SUM_THR_ADDR = 4'b0011;
    localparam logic [3:0] PE0_ADDR     = 4'b0100;
    localparam logic [3:0] PE1_ADDR     = 4'b0101;
    localparam logic [3:0] PE2_ADDR     = 4'b0110;

    localparam int ACC_W = 12;
    localparam int MEM_W = 11;
    localparam logic [MEM_W-1:0] MEM_MAX = 11'h7FF;

    typedef enum logic [1:0] {
        ACCUM,
        FIRE,
        SEND
    } state_t;

endpackage

// File: rtl/sum_threshold_unit_if.sv
// Packet-stream bundle between the NoC router and the sum/threshold endpoint:
// psum input stream and spike output stream, both valid/ready.
interface sum_threshold_unit_if #(
    parameter int WIDTH = 35
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/st_fire_unit.sv
// Combinational membrane update: saturating residual+acc sum, threshold compare
// and the residual carried into the next timestep.
module st_fire_unit
    import snn_noc_pkg::*;
#(
    parameter int THRESHOLD = 64
) (
    input  logic [MEM_W-1:0] residual,
    input  logic [ACC_W-1:0] acc,
    output logic [MEM_W-1:0] m,
    output logic             spike,
    output logic [MEM_W-1:0] next_residual
);
    localparam logic [MEM_W-1:0] THR = MEM_W'(THRESHOLD);

    function automatic logic [MEM_W-1:0] sat_mem(input logic [ACC_W:0] x);
        if (x > (ACC_W+1)'(MEM_MAX))
            return MEM_MAX;
        return x[MEM_W-1:0];
    endfunction

    // one extra bit holds the worst case 2047 + 4095 without wrap
    logic [ACC_W:0] sum;

    assign sum           = (ACC_W+1)'(residual) + (ACC_W+1)'(acc);
    assign m             = sat_mem(sum);
    assign spike         = (m >= THR);
    assign next_residual = spike ? (m - THR) : m;

endmodule

// File: rtl/sum_threshold_unit.sv
// Sum/threshold NoC endpoint: accumulates NUM_PSUM psum packets per timestep,
// adds the residual potential, fires against THRESHOLD and sends a spike packet.
module sum_threshold_unit
    import snn_noc_pkg::*;
#(
    parameter int         WIDTH     = 35,
    parameter logic [3:0] ST_ADDR   = SUM_THR_ADDR,
    parameter logic [3:0] OUT_DST   = OUT_MEM_ADDR,
    parameter int         NUM_PSUM  = 3,
    parameter int         NUM_TS    = 10,
    parameter int         THRESHOLD = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    sum_threshold_unit_if.slave  bus,
    output logic                 layer_done,
    output logic                 err_drop
);
    state_t           state;
    logic [ACC_W-1:0] acc;
    logic [MEM_W-1:0] residual;
    logic [3:0]       psum_cnt;
    logic [7:0]       ts_cnt;

    logic [MEM_W-1:0] m;
    logic [MEM_W-1:0] next_residual;
    logic             spike;
    logic             accept;
    logic             pkt_ok;
    logic [WIDTH-1:0] spike_pkt;
    logic             unused_src;

    assign accept = bus.in_valid && bus.in_ready;
    assign pkt_ok = (bus.in_data[DST_MSB:DST_LSB] == ST_ADDR) &&
                    (bus.in_data[PAD_MSB:PAD_LSB] == '0);

    // source ids are carried for routing/debug only; nothing here depends on them
    assign unused_src = ^{bus.in_data[SRC_MSB:SRC_LSB], bus.in_data[SRCCP_MSB:SRCCP_LSB]};

    st_fire_unit #(
        .THRESHOLD(THRESHOLD)
    ) u_fire (
        .residual     (residual),
        .acc          (acc),
        .m            (m),
        .spike        (spike),
        .next_residual(next_residual)
    );

    always_comb begin
        spike_pkt                       = '0;
        spike_pkt[SRC_MSB:SRC_LSB]      = ST_ADDR;
        spike_pkt[DST_MSB:DST_LSB]      = OUT_DST;
        spike_pkt[TYPE_MSB:TYPE_LSB]    = TYPE_SPIKE;
        spike_pkt[SPIKE_BIT]            = spike;
        spike_pkt[MEM_MSB:PAYLOAD_LSB]  = m;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= ACCUM;
            bus.in_ready  <= 1'b0;
            bus.out_valid <= 1'b0;
            bus.out_data  <= '0;
            layer_done    <= 1'b0;
            err_drop      <= 1'b0;
            acc           <= '0;
            residual      <= '0;
            psum_cnt      <= '0;
            ts_cnt        <= '0;
        end else begin
            layer_done <= 1'b0;
            case (state)
                ACCUM: begin
                    bus.in_ready <= 1'b1;
                    if (accept) begin
                        if (pkt_ok) begin
                            acc      <= acc + ACC_W'(bus.in_data[PSUM_MSB:PSUM_LSB]);
                            psum_cnt <= psum_cnt + 4'd1;
                            if (psum_cnt == 4'(NUM_PSUM - 1)) begin
                                bus.in_ready <= 1'b0;
                                state        <= FIRE;
                            end
                        end else begin
                            err_drop <= 1'b1;
                        end
                    end
                end
                FIRE: begin
                    bus.out_data  <= spike_pkt;
                    bus.out_valid <= 1'b1;
                    residual      <= next_residual;
                    acc           <= '0;
                    psum_cnt      <= '0;
                    state         <= SEND;
                end
                SEND: begin
                    if (bus.out_ready) begin
                        bus.out_valid <= 1'b0;
                        bus.in_ready  <= 1'b1;
                        state         <= ACCUM;
                        // the last timestep of a layer clears the carried potential
                        if (ts_cnt == 8'(NUM_TS - 1)) begin
                            ts_cnt     <= '0;
                            residual   <= '0;
                            layer_done <= 1'b1;
                        end else begin
                            ts_cnt <= ts_cnt + 8'd1;
                        end
                    end
                end
                default: state <= ACCUM;
            endcase
        end
    end

endmodule

// File: tb/tb_sum_threshold_unit.sv
// Scoreboard bench for sum_threshold_unit: a small-threshold instance for the
// handshake/drop/reset cases and a second instance for saturation over timesteps.
module tb_sum_threshold_unit;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    sum_threshold_unit_if #(.WIDTH(35)) bus_a ();
    sum_threshold_unit_if #(.WIDTH(35)) bus_b ();
    logic layer_done_a, err_drop_a, layer_done_b, err_drop_b;

    sum_threshold_unit #(
        .WIDTH(35), .ST_ADDR(4'b0011), .OUT_DST(4'b0000),
        .NUM_PSUM(3), .NUM_TS(2), .THRESHOLD(16)
    ) dut_a (
        .clk(clk), .rst(rst), .bus(bus_a.slave),
        .layer_done(layer_done_a), .err_drop(err_drop_a)
    );

    sum_threshold_unit #(
        .WIDTH(35), .ST_ADDR(4'b0011), .OUT_DST(4'b0000),
        .NUM_PSUM(3), .NUM_TS(10), .THRESHOLD(16)
    ) dut_b (
        .clk(clk), .rst(rst), .bus(bus_b.slave),
        .layer_done(layer_done_b), .err_drop(err_drop_b)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", tag, act, exp);
        end
    endtask

    // reference model for instance A (THRESHOLD=16, NUM_TS=2, NUM_PSUM=3)
    int m_res = 0, m_acc = 0, m_cnt = 0, m_ts = 0;
    logic [34:0] sb_q[$];
    bit          ld_q[$];

    function automatic logic [34:0] mk_out(input int m, input bit s);
        logic [10:0] mm;
        mm = 11'(m);
        return {4'd3, 4'd0, 3'b010, 12'd0, s, mm};
    endfunction

    task automatic model_psum(input int p);
        int sum;
        bit sp;
        m_acc += p;
        m_cnt++;
        if (m_cnt == 3) begin
            sum = m_res + m_acc;
            if (sum > 2047) sum = 2047;
            sp = (sum >= 16);
            sb_q.push_back(mk_out(sum, sp));
            m_res = sp ? sum - 16 : sum;
            m_acc = 0;
            m_cnt = 0;
            m_ts++;
            if (m_ts == 2) begin
                m_ts  = 0;
                m_res = 0;
                ld_q.push_back(1'b1);
            end else begin
                ld_q.push_back(1'b0);
            end
        end
    endtask

    // output monitor for instance A
    initial begin
        bit ld_pending;
        bit ld_exp;
        ld_pending = 0;
        ld_exp     = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                ld_pending = 0;
            end else begin
                if (ld_pending) begin
                    chk("layer_done", layer_done_a, ld_exp);
                    ld_pending = 0;
                end else begin
                    chk("layer_done_idle", layer_done_a, 1'b0);
                end
                if (bus_a.out_valid && bus_a.out_ready) begin
                    if (sb_q.size() == 0) begin
                        chk("unexpected_out", sb_q.size(), 1);
                    end else begin
                        chk("out_data", bus_a.out_data, sb_q.pop_front());
                        ld_exp     = ld_q.pop_front();
                        ld_pending = 1;
                    end
                end
            end
        end
    end

    task automatic wait_accept_a(input logic [3:0] dst, input logic [14:0] zf, input logic [7:0] p);
        int n;
        bit ok;
        n  = 0;
        ok = 0;
        while (n < 50 && !ok) begin
            @(negedge clk);
            if (bus_a.in_ready) ok = 1;
            else n++;
        end
        if (ok) begin
            @(posedge clk);
            #1;
            bus_a.in_valid = 1'b0;
            if (dst == 4'd3 && zf == 15'd0) model_psum(int'(p));
        end else begin
            chk("accept_timeout", n, 0);
            bus_a.in_valid = 1'b0;
        end
    endtask

    task automatic drive_a(input logic [3:0] dst, input logic [14:0] zf, input logic [7:0] p);
        @(posedge clk);
        #1;
        bus_a.in_data  = {4'd5, dst, 4'd5, zf, p};
        bus_a.in_valid = 1'b1;
    endtask

    task automatic send_a(input logic [3:0] dst, input logic [14:0] zf, input logic [7:0] p);
        drive_a(dst, zf, p);
        wait_accept_a(dst, zf, p);
    endtask

    task automatic drain_a();
        int n;
        n = 0;
        while (sb_q.size() != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("drain_a", sb_q.size(), 0);
        @(negedge clk);
    endtask

    task automatic send_b(input logic [7:0] p);
        int n;
        bit ok;
        @(posedge clk);
        #1;
        bus_b.in_data  = {4'd6, 4'd3, 4'd6, 15'd0, p};
        bus_b.in_valid = 1'b1;
        n  = 0;
        ok = 0;
        while (n < 50 && !ok) begin
            @(negedge clk);
            if (bus_b.in_ready) ok = 1;
            else n++;
        end
        if (ok) @(posedge clk);
        else chk("accept_timeout_b", n, 0);
        #1;
        bus_b.in_valid = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst            = 1'b1;
        bus_a.in_valid = 1'b0;
        bus_b.in_valid = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_out_valid",  bus_a.out_valid, 1'b0);
        chk("rst_out_data",   bus_a.out_data, 35'd0);
        chk("rst_in_ready",   bus_a.in_ready, 1'b0);
        chk("rst_layer_done", layer_done_a, 1'b0);
        chk("rst_err_drop",   err_drop_a, 1'b0);
        m_res = 0; m_acc = 0; m_cnt = 0; m_ts = 0;
        sb_q.delete();
        ld_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("in_ready_pre", bus_a.in_ready, 1'b0);
        @(negedge clk);
        chk("in_ready_post_rst", bus_a.in_ready, 1'b1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int res_b, sum_b;
        bit sp_b;
        int n;
        logic [7:0] ts_psum [4];

        bus_a.in_valid  = 1'b0;
        bus_a.in_data   = '0;
        bus_a.out_ready = 1'b1;
        bus_b.in_valid  = 1'b0;
        bus_b.in_data   = '0;
        bus_b.out_ready = 1'b1;

        do_reset();

        // first timestep fires, second closes the layer
        send_a(4'd3, 15'd0, 8'd5);
        send_a(4'd3, 15'd0, 8'd6);
        send_a(4'd3, 15'd0, 8'd7);
        drain_a();
        send_a(4'd3, 15'd0, 8'd1);
        send_a(4'd3, 15'd0, 8'd2);
        send_a(4'd3, 15'd0, 8'd3);
        drain_a();
        chk("err_drop_clean", err_drop_a, 1'b0);

        // misaddressed and malformed packets mixed into a timestep
        send_a(4'd3, 15'd0, 8'd10);
        send_a(4'd7, 15'd0, 8'd50);
        @(negedge clk);
        chk("err_drop_dst", err_drop_a, 1'b1);
        send_a(4'd3, 15'd0, 8'd20);
        send_a(4'd3, 15'd1, 8'd99);
        send_a(4'd3, 15'd0, 8'd30);
        drain_a();
        chk("err_drop_sticky", err_drop_a, 1'b1);

        // backpressure on the spike output while a psum waits upstream
        bus_a.out_ready = 1'b0;
        send_a(4'd3, 15'd0, 8'd1);
        send_a(4'd3, 15'd0, 8'd1);
        send_a(4'd3, 15'd0, 8'd1);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus_a.out_valid && n < 20);
        chk("out_valid_rise", bus_a.out_valid, 1'b1);
        drive_a(4'd3, 15'd0, 8'd9);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("hold_out_valid", bus_a.out_valid, 1'b1);
            chk("hold_out_data", bus_a.out_data, sb_q[0]);
            chk("hold_in_ready", bus_a.in_ready, 1'b0);
        end
        @(posedge clk);
        #1;
        bus_a.out_ready = 1'b1;
        wait_accept_a(4'd3, 15'd0, 8'd9);
        send_a(4'd3, 15'd0, 8'd8);

        // reset with two psums already accumulated
        do_reset();
        send_a(4'd3, 15'd0, 8'd4);
        send_a(4'd3, 15'd0, 8'd4);
        send_a(4'd3, 15'd0, 8'd4);
        drain_a();

        // saturation over several timesteps on instance B
        ts_psum[0] = 8'd255;
        ts_psum[1] = 8'd255;
        ts_psum[2] = 8'd255;
        ts_psum[3] = 8'd0;
        res_b = 0;
        for (int t = 0; t < 4; t++) begin
            send_b(ts_psum[t]);
            send_b(ts_psum[t]);
            send_b(ts_psum[t]);
            sum_b = res_b + 3 * int'(ts_psum[t]);
            if (sum_b > 2047) sum_b = 2047;
            sp_b  = (sum_b >= 16);
            res_b = sp_b ? sum_b - 16 : sum_b;
            n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (!bus_b.out_valid && n < 20);
            chk("sat_out_data", bus_b.out_data, mk_out(sum_b, sp_b));
        end
        chk("err_drop_b", err_drop_b, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
